// File: rtl/heartbeat_generator_if.sv
// heartbeat_generator_if: groups the liveness, watchdog-status and kick
// signals of the heartbeat generator. Signal suffixes are from the
// generator's point of view (_i into the generator, _o out of it).
interface heartbeat_generator_if #(
    parameter int NUM_SRC = 4
);
    logic               enable_i;
    logic [NUM_SRC-1:0] alive_i;
    logic               warning_i;
    logic               triggered_i;
    logic               heartbeat_o;
    logic [NUM_SRC-1:0] missing_o;
    logic [15:0]        kick_count_o;
    logic [1:0]         state_o;

    // Environment side: drives enable/liveness/watchdog status, observes kicks.
    modport master (
        output enable_i, alive_i, warning_i, triggered_i,
        input  heartbeat_o, missing_o, kick_count_o, state_o
    );

    // Generator side.
    modport slave (
        input  enable_i, alive_i, warning_i, triggered_i,
        output heartbeat_o, missing_o, kick_count_o, state_o
    );
endinterface

// File: rtl/heartbeat_generator.sv
// heartbeat_generator: kicks the watchdog once per collection window, but
// only when every liveness source strobed at least once during that window.
// A window that ends with silent sources records them in missing_o and the
// kick is withheld. A watchdog expiry parks the block in HOLDOFF until the
// expiry has been gone for HOLDOFF cycles.
// Optional feature: define HB_WARN_KICK_EN to allow an early kick on a rising
// watchdog warning when all sources have already reported in this window.
module heartbeat_generator #(
    parameter int KICK_PERIOD = 1000,
    parameter int NUM_SRC     = 4,
    parameter int HOLDOFF     = 16
) (
    input  logic               clk,
    input  logic               rst,
    heartbeat_generator_if.slave bus
);
    localparam int CW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(KICK_PERIOD - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_KICK    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_SRC-1:0] seen_q, seen_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic               heartbeat_q, heartbeat_d;
    logic [NUM_SRC-1:0] missing_q, missing_d;
    logic [15:0]        kick_count_q, kick_count_d;

    logic [NUM_SRC-1:0] seen_now;
    logic               all_ok;
    logic               win_end;
    logic               warn_rise;

    // Sources seen so far including this cycle's strobes; the decision cycle
    // itself still counts toward the window.
    assign seen_now = seen_q | bus.alive_i;
    assign all_ok   = &seen_now;
    assign win_end  = (cnt_q == CNT_LAST);

`ifdef HB_WARN_KICK_EN
    logic warn_q;

    // Previous warning level, for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) warn_q <= 1'b0;
        else     warn_q <= bus.warning_i;
    end

    assign warn_rise = bus.warning_i & ~warn_q;
`else
    logic unused_warning;
    assign unused_warning = bus.warning_i;
    assign warn_rise      = 1'b0;
`endif

    // Next-state, counter and output-register logic. Window/holdoff counters
    // default to zero so every entry into COLLECT or HOLDOFF starts clean.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        seen_d       = '0;
        hcnt_d       = '0;
        missing_d    = missing_q;
        kick_count_d = kick_count_q;
        heartbeat_d  = 1'b0;

        if (!bus.enable_i) begin
            state_d = ST_IDLE;
        end else if (bus.triggered_i &&
                     (state_q == ST_COLLECT || state_q == ST_KICK)) begin
            state_d = ST_HOLDOFF;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (all_ok && (win_end || warn_rise)) begin
                        state_d = ST_KICK;
                    end else if (win_end) begin
                        // Failed window: report the silent sources, restart.
                        missing_d = ~seen_now;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        seen_d = seen_now;
                    end
                end
                ST_KICK: begin
                    // Strobes arriving during the kick cycle are dropped.
                    state_d = ST_COLLECT;
                end
                ST_HOLDOFF: begin
                    if (!bus.triggered_i) begin
                        if (hcnt_q == HCNT_LAST) state_d = ST_COLLECT;
                        else                     hcnt_d  = hcnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The kick pulse and its bookkeeping are registered together with
        // the move into KICK so heartbeat is high exactly in the KICK cycle.
        if (state_d == ST_KICK) begin
            heartbeat_d = 1'b1;
            missing_d   = '0;
            if (kick_count_q != 16'hFFFF) kick_count_d = kick_count_q + 16'd1;
        end
    end

    // State and output registers; reset clears the kick pulse at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            seen_q       <= '0;
            hcnt_q       <= '0;
            heartbeat_q  <= 1'b0;
            missing_q    <= '0;
            kick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            hcnt_q       <= hcnt_d;
            heartbeat_q  <= heartbeat_d;
            missing_q    <= missing_d;
            kick_count_q <= kick_count_d;
        end
    end

    assign bus.heartbeat_o  = heartbeat_q;
    assign bus.missing_o    = missing_q;
    assign bus.kick_count_o = kick_count_q;
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_heartbeat_generator.sv
// tb_heartbeat_generator: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_heartbeat_generator;
    localparam int P = 8;
    localparam int N = 2;
    localparam int H = 4;
`ifdef HB_WARN_KICK_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    heartbeat_generator_if #(.NUM_SRC(N)) bus ();

    heartbeat_generator #(
        .KICK_PERIOD(P),
        .NUM_SRC    (N),
        .HOLDOFF    (H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // Behavioural model: phase 0 idle, 1 collecting, 2 kicking, 3 holding off.
    int       m_st, m_pos, m_h, m_kc;
    logic [1:0] m_seen, m_miss;
    bit       m_hb, m_wprev;

    // Per-cycle log of observed outputs for literal scenario checks.
    logic       hb_at [0:63];
    logic [1:0] st_at [0:63];
    logic [1:0] miss_at [0:63];
    logic [15:0] kc_at [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_h = 0; m_kc = 0;
        m_seen = '0; m_miss = '0; m_hb = 0; m_wprev = 0;
    endtask

    task automatic model_step(input bit en, input logic [1:0] al, input bit wn, input bit tr);
        int nst;
        logic [1:0] got;
        bit ok, rise;
        got  = m_seen | al;
        ok   = (got == 2'b11);
        rise = WARN_EN && wn && !m_wprev;
        m_wprev = wn;
        nst = m_st;
        if (!en) begin
            nst = 0;
        end else if (tr && (m_st == 1 || m_st == 2)) begin
            nst = 3;
        end else if (m_st == 0 || m_st == 2) begin
            nst = 1; m_pos = 0; m_seen = '0;
        end else if (m_st == 1) begin
            if (ok && (m_pos == P - 1 || rise)) begin
                nst = 2;
            end else if (m_pos == P - 1) begin
                m_miss = ~got; m_pos = 0; m_seen = '0;
            end else begin
                m_pos++; m_seen = got;
            end
        end else begin
            if (tr)              m_h = 0;
            else if (m_h == H-1) begin nst = 1; m_pos = 0; m_seen = '0; end
            else                 m_h++;
        end
        if (nst == 3 && m_st != 3) m_h = 0;
        m_hb = (nst == 2);
        if (m_hb) begin
            if (m_kc < 65535) m_kc++;
            m_miss = '0;
        end
        m_st = nst;
    endtask

    // Compare current outputs with the model, log, drive this cycle's inputs,
    // advance the model, then move to the next cycle.
    task automatic run_cycle(input bit en, input logic [1:0] al, input bit wn, input bit tr);
        chk("heartbeat",  {31'd0, bus.heartbeat_o}, {31'd0, m_hb});
        chk("missing",    {30'd0, bus.missing_o},   {30'd0, m_miss});
        chk("kick_count", {16'd0, bus.kick_count_o}, m_kc);
        chk("state",      {30'd0, bus.state_o},     m_st);
        if (cyc < 64) begin
            hb_at[cyc] = bus.heartbeat_o;
            st_at[cyc] = bus.state_o;
            miss_at[cyc] = bus.missing_o;
            kc_at[cyc] = bus.kick_count_o;
        end
        if (bus.heartbeat_o === 1'b1)
            $display("[TB] kick at cycle %0d, kick_count %0d", cyc, bus.kick_count_o);
        bus.enable_i    = en;
        bus.alive_i     = al;
        bus.warning_i   = wn;
        bus.triggered_i = tr;
        model_step(en, al, wn, tr);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.enable_i = 0; bus.alive_i = '0; bus.warning_i = 0; bus.triggered_i = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            hb_at[i] = 0; st_at[i] = 0; miss_at[i] = 0; kc_at[i] = 0;
        end
        cyc = 0;
    endtask

    function automatic int hb_count(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (hb_at[i] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        bus.enable_i = 0; bus.alive_i = '0; bus.warning_i = 0; bus.triggered_i = 0;

        // Reset state
        do_reset();
        chk("reset_state", {30'd0, bus.state_o}, 0);
        chk("reset_heartbeat", {31'd0, bus.heartbeat_o}, 0);
        chk("reset_kick_count", {16'd0, bus.kick_count_o}, 0);
        chk("reset_missing", {30'd0, bus.missing_o}, 0);

        // Steady health
        for (int c = 0; c < 29; c++) run_cycle(1, 2'b11, 0, 0);
        chk("steady_hb9",  {31'd0, hb_at[9]},  1);
        chk("steady_hb10", {31'd0, hb_at[10]}, 0);
        chk("steady_hb18", {31'd0, hb_at[18]}, 1);
        chk("steady_hb27", {31'd0, hb_at[27]}, 1);
        chk("steady_pulses", hb_count(0, 28), 3);
        chk("steady_count", {16'd0, kc_at[28]}, 3);
        chk("steady_missing", {30'd0, miss_at[28]}, 0);
        $display("[TB] steady health done");

        // Stalled source
        do_reset();
        for (int c = 0; c < 20; c++) run_cycle(1, 2'b01, 0, 0);
        chk("stall_pulses", hb_count(0, 19), 0);
        chk("stall_miss8", {30'd0, miss_at[8]}, 0);
        chk("stall_miss9", {30'd0, miss_at[9]}, 2);
        chk("stall_state", {30'd0, st_at[15]}, 1);
        $display("[TB] stalled source done");

        // Sparse strobes
        do_reset();
        for (int c = 0; c < 12; c++)
            run_cycle(1, (c == 2) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00, 0, 0);
        chk("sparse_hb9", {31'd0, hb_at[9]}, 1);
        chk("sparse_pulses", hb_count(0, 11), 1);
        $display("[TB] sparse strobes done");

        // Watchdog expiry
        do_reset();
        for (int c = 0; c < 16; c++) run_cycle(1, 2'b11, 0, (c >= 4 && c <= 6));
        chk("expiry_st5",  {30'd0, st_at[5]},  3);
        chk("expiry_st10", {30'd0, st_at[10]}, 3);
        chk("expiry_st11", {30'd0, st_at[11]}, 1);
        chk("expiry_pulses", hb_count(0, 15), 0);
        $display("[TB] watchdog expiry done");

        // Disable
        do_reset();
        for (int c = 0; c < 16; c++) run_cycle(c < 5, 2'b11, 0, 0);
        chk("disable_st5", {30'd0, st_at[5]}, 1);
        chk("disable_st6", {30'd0, st_at[6]}, 0);
        chk("disable_pulses", hb_count(0, 15), 0);
        chk("disable_count", {16'd0, kc_at[15]}, 0);
        $display("[TB] disable done");

        // Reset during the kick cycle
        do_reset();
        for (int c = 0; c < 9; c++) run_cycle(1, 2'b11, 0, 0);
        chk("rstkick_hb_before", {31'd0, bus.heartbeat_o}, 1);
        chk("rstkick_kc_before", {16'd0, bus.kick_count_o}, 1);
        rst = 1'b1;
        #1;
        chk("rstkick_hb_after", {31'd0, bus.heartbeat_o}, 0);
        chk("rstkick_kc_after", {16'd0, bus.kick_count_o}, 0);
        chk("rstkick_state", {30'd0, bus.state_o}, 0);
        $display("[TB] reset during kick done");

        // Warning-driven kick
        do_reset();
        for (int c = 0; c < 12; c++) run_cycle(1, 2'b11, (c >= 3), 0);
        chk("warn_hb4", {31'd0, hb_at[4]}, WARN_EN ? 1 : 0);
        chk("warn_hb9", {31'd0, hb_at[9]}, WARN_EN ? 0 : 1);
        $display("[TB] warning kick done");

        // Randomized run
        do_reset();
        begin
            int tr_left = 0;
            bit wn = 0;
            for (int c = 0; c < 4000; c++) begin
                logic [1:0] al;
                bit en, tr;
                en = ($urandom_range(0, 99) < 97);
                al[0] = ($urandom_range(0, 99) < 40);
                al[1] = ($urandom_range(0, 99) < 40);
                if (tr_left == 0 && $urandom_range(0, 149) == 0) tr_left = $urandom_range(1, 6);
                tr = (tr_left != 0);
                if (tr_left != 0) tr_left--;
                if ($urandom_range(0, 9) == 0) wn = ~wn;
                run_cycle(en, al, wn, tr);
            end
        end
        $display("[TB] random run done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
